// File: rtl/ras_free_list_pkg.sv
// Shared types and helpers for the return-address-stack free-list allocator.
package ras_pkg;

    typedef enum logic [1:0] {
        INIT,
        PRIME,
        RUN
    } alloc_state_t;

    // Successor of node idx in the freshly built list; dir is +1 or -1.
    function automatic int wrap_link(input int idx, input int dir, input int depth);
        return (idx + depth + dir) % depth;
    endfunction

endpackage

// File: rtl/ras_free_list_bram.sv
// Simple dual-port RAM: port A registered read (1-cycle latency), port B write.
module bram #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int BLANK  = 1,
    parameter int AWIDTH = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              a_en,
    input  logic [AWIDTH-1:0] a_addr,
    output logic [WIDTH-1:0]  a_dout,
    input  logic              b_en,
    input  logic [AWIDTH-1:0] b_addr,
    input  logic [WIDTH-1:0]  b_din
);

    logic [WIDTH-1:0] mem [DEPTH];

    // With BLANK set the read port shows zero on cycles without a read.
    always_ff @(posedge clk) begin
        if (a_en) begin
            a_dout <= mem[a_addr];
        end else if (BLANK != 0) begin
            a_dout <= '0;
        end
        if (b_en) begin
            mem[b_addr] <= b_din;
        end
    end

endmodule

// File: rtl/ras_free_list.sv
// Free-list allocator: free node addresses form a linked list in a link RAM,
// one allocation per cycle with a registered head/next pair.
module ras_free_list
    import ras_pkg::*;
#(
    parameter int ADDR      = 4,
    parameter int DEPTH     = 16,
    parameter int DIRECTION = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alloc_valid,
    output logic            alloc_ready,
    output logic [ADDR-1:0] alloc_addr,
    input  logic            free_valid,
    input  logic [ADDR-1:0] free_addr,
    input  logic            chain_valid,
    input  logic [ADDR-1:0] chain_start,
    input  logic [ADDR-1:0] chain_snd,
    input  logic [ADDR-1:0] chain_end,
    input  logic [ADDR:0]   chain_len,
    input  logic            rewind,
    input  logic [ADDR-1:0] rewind_addr,
    input  logic [ADDR:0]   rewind_count,
    output logic [ADDR:0]   free_count,
    output logic            empty,
    output logic            overflow_err
);

    typedef logic [ADDR:0] count_t;

    localparam logic [ADDR+1:0] DEPTH_W   = (ADDR+2)'(DEPTH);
    localparam logic [ADDR-1:0] LAST_IDX  = ADDR'(DEPTH - 1);
    localparam logic [ADDR-1:0] FIRST_NXT = ADDR'(wrap_link(0, DIRECTION, DEPTH));

    alloc_state_t    state_q, state_d;
    logic [ADDR-1:0] head_q, head_d;
    logic [ADDR-1:0] next_q, next_d;
    logic [ADDR-1:0] init_idx_q, init_idx_d;
    logic            next_from_ram_q, next_from_ram_d;
    count_t          count_q, count_d;
    logic            overflow_q;

    logic [ADDR-1:0] ram_dout;
    logic [ADDR-1:0] next_val;
    logic            a_en, b_en;
    logic [ADDR-1:0] a_addr, b_addr, b_din;

    logic            in_run, alloc_fire;
    logic            chain_req, free_req, ovf, do_chain, do_free;
    count_t          add_n;
    logic [ADDR+1:0] sum_n;

    assign next_val    = next_from_ram_q ? ram_dout : next_q;
    assign in_run      = (state_q == RUN);
    assign alloc_ready = in_run && (count_q != '0) && !rewind;
    assign alloc_fire  = alloc_valid && alloc_ready;

    // Rewind outranks chain, chain outranks free; an overflowing return is dropped.
    assign chain_req = in_run && !rewind && chain_valid;
    assign free_req  = in_run && !rewind && !chain_valid && free_valid;
    assign add_n     = chain_req ? chain_len : count_t'(free_req);
    assign sum_n     = {1'b0, count_q} + {1'b0, add_n};
    assign ovf       = (chain_req || free_req) && (sum_n > DEPTH_W);
    assign do_chain  = chain_req && !ovf;
    assign do_free   = free_req && !ovf;

    always_comb begin
        state_d         = state_q;
        head_d          = head_q;
        next_d          = next_val;
        next_from_ram_d = 1'b0;
        count_d         = count_q;
        init_idx_d      = init_idx_q;
        a_en            = 1'b0;
        a_addr          = next_val;
        b_en            = 1'b0;
        b_addr          = init_idx_q;
        b_din           = ADDR'(wrap_link(int'(init_idx_q), DIRECTION, DEPTH));
        case (state_q)
            INIT: begin
                b_en = 1'b1;
                if (init_idx_q == LAST_IDX) begin
                    state_d = RUN;
                    head_d  = '0;
                    next_d  = FIRST_NXT;
                    count_d = count_t'(DEPTH);
                end else begin
                    init_idx_d = init_idx_q + ADDR'(1);
                end
            end
            PRIME: begin
                next_d  = ram_dout;
                state_d = RUN;
            end
            RUN: begin
                if (rewind) begin
                    head_d  = rewind_addr;
                    count_d = rewind_count;
                    a_en    = 1'b1;
                    a_addr  = rewind_addr;
                    state_d = PRIME;
                end else if (do_chain) begin
                    b_en    = 1'b1;
                    b_addr  = chain_end;
                    b_din   = alloc_fire ? next_val : head_q;
                    head_d  = chain_start;
                    next_d  = (chain_len == count_t'(1)) ? b_din : chain_snd;
                    count_d = count_q + chain_len - count_t'(alloc_fire);
                end else if (do_free) begin
                    b_en    = 1'b1;
                    b_addr  = free_addr;
                    b_din   = alloc_fire ? next_val : head_q;
                    head_d  = free_addr;
                    next_d  = b_din;
                    count_d = count_q + count_t'(1) - count_t'(alloc_fire);
                end else if (alloc_fire) begin
                    head_d          = next_val;
                    a_en            = 1'b1;
                    a_addr          = next_val;
                    next_from_ram_d = 1'b1;
                    count_d         = count_q - count_t'(1);
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= INIT;
            head_q          <= '0;
            next_q          <= '0;
            init_idx_q      <= '0;
            next_from_ram_q <= 1'b0;
            count_q         <= '0;
            overflow_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            head_q          <= head_d;
            next_q          <= next_d;
            init_idx_q      <= init_idx_d;
            next_from_ram_q <= next_from_ram_d;
            count_q         <= count_d;
            overflow_q      <= overflow_q | ovf;
        end
    end

    bram #(
        .WIDTH (ADDR),
        .DEPTH (DEPTH),
        .BLANK (1),
        .AWIDTH(ADDR)
    ) link_ram (
        .clk   (clk),
        .a_en  (a_en),
        .a_addr(a_addr),
        .a_dout(ram_dout),
        .b_en  (b_en),
        .b_addr(b_addr),
        .b_din (b_din)
    );

    assign alloc_addr   = head_q;
    assign free_count   = count_q;
    assign empty        = (count_q == '0);
    assign overflow_err = overflow_q;

    chain_free_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
        !(chain_valid && free_valid));

endmodule

// File: tb/tb_ras_free_list.sv
// Directed self-checking bench for ras_free_list (ADDR=4, DEPTH=16, DIRECTION=+1).
module tb_ras_free_list;

    localparam int ADDR  = 4;
    localparam int DEPTH = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            alloc_valid;
    logic            alloc_ready;
    logic [ADDR-1:0] alloc_addr;
    logic            free_valid;
    logic [ADDR-1:0] free_addr;
    logic            chain_valid;
    logic [ADDR-1:0] chain_start, chain_snd, chain_end;
    logic [ADDR:0]   chain_len;
    logic            rewind;
    logic [ADDR-1:0] rewind_addr;
    logic [ADDR:0]   rewind_count;
    logic [ADDR:0]   free_count;
    logic            empty;
    logic            overflow_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ras_free_list #(.ADDR(ADDR), .DEPTH(DEPTH), .DIRECTION(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alloc_valid (alloc_valid),
        .alloc_ready (alloc_ready),
        .alloc_addr  (alloc_addr),
        .free_valid  (free_valid),
        .free_addr   (free_addr),
        .chain_valid (chain_valid),
        .chain_start (chain_start),
        .chain_snd   (chain_snd),
        .chain_end   (chain_end),
        .chain_len   (chain_len),
        .rewind      (rewind),
        .rewind_addr (rewind_addr),
        .rewind_count(rewind_count),
        .free_count  (free_count),
        .empty       (empty),
        .overflow_err(overflow_err)
    );

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic check_state(input string tag, input logic ready, input int addr,
                               input int count);
        check_output({tag, "_ready"}, 32'(alloc_ready), 32'(ready));
        check_output({tag, "_addr"}, 32'(alloc_addr), addr);
        check_output({tag, "_count"}, 32'(free_count), count);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_idle();
        alloc_valid  = 1'b0;
        free_valid   = 1'b0;
        free_addr    = '0;
        chain_valid  = 1'b0;
        chain_start  = '0;
        chain_snd    = '0;
        chain_end    = '0;
        chain_len    = '0;
        rewind       = 1'b0;
        rewind_addr  = '0;
        rewind_count = '0;
    endtask

    task automatic apply_free(input int addr);
        free_valid = 1'b1;
        free_addr  = ADDR'(addr);
        tick();
        free_valid = 1'b0;
    endtask

    // Hold reset across a clock edge, check reset outputs, then walk the list build.
    task automatic reset_and_init();
        rst_n = 1'b0;
        tick();
        check_output("rst_ready", 32'(alloc_ready), 0);
        check_output("rst_addr", 32'(alloc_addr), 0);
        check_output("rst_count", 32'(free_count), 0);
        check_output("rst_empty", 32'(empty), 1);
        check_output("rst_ovf", 32'(overflow_err), 0);
        rst_n = 1'b1;
        repeat (DEPTH - 1) tick();
        check_output("init_busy_ready", 32'(alloc_ready), 0);
        tick();
        check_state("init_done", 1'b1, 0, DEPTH);
        check_output("init_done_empty", 32'(empty), 0);
    endtask

    initial begin
        apply_idle();
        reset_and_init();

        // Drain the whole list back to back.
        alloc_valid = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            check_output("burst_addr", 32'(alloc_addr), k);
            tick();
        end
        alloc_valid = 1'b0;
        check_output("drained_empty", 32'(empty), 1);
        check_output("drained_ready", 32'(alloc_ready), 0);
        check_output("drained_count", 32'(free_count), 0);

        reset_and_init();

        // Three allocs, free node 1, then allocs return 1,3,4.
        alloc_valid = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        alloc_valid = 1'b0;
        check_state("three_allocs", 1'b1, 3, 13);
        apply_free(1);
        check_state("free1", 1'b1, 1, 14);
        alloc_valid = 1'b1;
        tick();
        check_state("realloc1", 1'b1, 3, 13);
        tick();
        check_state("alloc3", 1'b1, 4, 12);
        tick();
        check_state("alloc4", 1'b1, 5, 11);

        // Alloc and free in the same cycle: 5 granted, 2 becomes head.
        free_valid = 1'b1;
        free_addr  = 4'd2;
        tick();
        free_valid = 1'b0;
        check_state("alloc_free", 1'b1, 2, 11);
        tick();
        alloc_valid = 1'b0;
        check_state("after_alloc2", 1'b1, 6, 10);

        // Rewind with a concurrent alloc request that must be dropped.
        rewind       = 1'b1;
        rewind_addr  = 4'd3;
        rewind_count = 5'd13;
        alloc_valid  = 1'b1;
        #1;
        check_output("rewind_cycle_ready", 32'(alloc_ready), 0);
        tick();
        rewind = 1'b0;
        check_state("prime", 1'b0, 3, 13);
        tick();
        check_state("rewound", 1'b1, 3, 13);
        tick();
        check_output("rw_alloc4", 32'(alloc_addr), 4);
        tick();
        check_output("rw_alloc5", 32'(alloc_addr), 5);
        repeat (5) tick();
        alloc_valid = 1'b0;
        check_state("head10", 1'b1, 10, 6);

        // Build link 9->4->7 by freeing, then take those three back out.
        apply_free(7);
        apply_free(4);
        apply_free(9);
        check_state("chain_built", 1'b1, 9, 9);
        alloc_valid = 1'b1;
        repeat (3) tick();
        check_state("chain_taken", 1'b1, 10, 6);

        // Splice chain 9->4->7 while allocating head 10.
        chain_valid = 1'b1;
        chain_start = 4'd9;
        chain_snd   = 4'd4;
        chain_end   = 4'd7;
        chain_len   = 5'd3;
        tick();
        chain_valid = 1'b0;
        check_state("spliced", 1'b1, 9, 8);
        tick();
        check_output("splice_4", 32'(alloc_addr), 4);
        tick();
        check_output("splice_7", 32'(alloc_addr), 7);
        tick();
        alloc_valid = 1'b0;
        check_state("splice_11", 1'b1, 11, 5);

        // Free into a full list is discarded and latches overflow.
        reset_and_init();
        apply_free(5);
        check_state("ovf_ignored", 1'b1, 0, DEPTH);
        check_output("ovf_set", 32'(overflow_err), 1);
        tick();
        check_output("ovf_sticky", 32'(overflow_err), 1);

        // Reset pulse in the middle of INIT restarts the build from index 0.
        rst_n = 1'b0;
        #1;
        check_output("ovf_cleared", 32'(overflow_err), 0);
        check_output("async_count", 32'(free_count), 0);
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        check_output("mid_init_ready", 32'(alloc_ready), 0);
        reset_and_init();
        alloc_valid = 1'b1;
        tick();
        alloc_valid = 1'b0;
        check_state("post_reinit_alloc", 1'b1, 1, DEPTH - 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
